// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, serial-adder state encoding and opcode check
package alu_pkg;

    localparam logic [1:0] ALU_OP_ADD = 2'b01;
    localparam logic [1:0] ALU_OP_SUB = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic op_is_legal(input logic [1:0] op);
        return (op == ALU_OP_ADD) || (op == ALU_OP_SUB);
    endfunction

endpackage

// File: rtl/nibble_add_slice.sv
// rtl/nibble_add_slice.sv - combinational 4-bit ripple adder slice built from fulladder cells
// fulladder:        a, b, cin -> s, cout (one-bit full adder cell)
// nibble_add_slice: a[3:0], b[3:0], cin -> s[3:0], cout
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module nibble_add_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        fulladder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    assign cout = c[4];
endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - NIBBLES*4-bit add/sub, one nibble per clock through a single 4-bit slice
// Inputs:  clk, reset (sync, active-high), start, op[1:0], a[W-1:0], b[W-1:0], carry_in
// Outputs: busy, done (pulse), valid (level), err (pulse), sum[W-1:0], carry_out, overflow, zero
module nibble_serial_adder
    import alu_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 carry_in,
    output logic                 busy,
    output logic                 done,
    output logic                 valid,
    output logic                 err,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 carry_out,
    output logic                 overflow,
    output logic                 zero
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, b_q, acc_q, acc_d;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;

    logic             can_start, accept, illegal, is_sub, last;
    logic [3:0]       slice_s;
    logic             slice_cout;

    // start is only looked at when no operation is in flight
    assign can_start = start && (state_q == IDLE || state_q == DONE);
    assign accept    = can_start && op_is_legal(op);
    assign illegal   = can_start && !op_is_legal(op);
    assign is_sub    = (op == ALU_OP_SUB);
    assign last      = (state_q == RUN) && (idx_q == LAST_IDX);

    nibble_add_slice u_slice (
        .a    (a_q[idx_q*4 +: 4]),
        .b    (b_q[idx_q*4 +: 4]),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // accumulator with the current nibble merged in; on the last nibble this is the full result
    always_comb begin
        acc_d = acc_q;
        acc_d[idx_q*4 +: 4] = slice_s;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = accept ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            valid     <= 1'b0;
            err       <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            err <= illegal;
            if (accept) begin
                // subtract is a + ~b + 1, so b is inverted once here and the slice only adds
                a_q     <= a;
                b_q     <= is_sub ? ~b : b;
                carry_q <= is_sub ? 1'b1 : carry_in;
                idx_q   <= '0;
                valid   <= 1'b0;
            end else if (state_q == RUN) begin
                acc_q   <= acc_d;
                carry_q <= slice_cout;
                idx_q   <= idx_q + IDX_W'(1);
                if (last) begin
                    sum       <= acc_d;
                    carry_out <= slice_cout;
                    overflow  <= (a_q[W-1] == b_q[W-1]) && (acc_d[W-1] != a_q[W-1]);
                    zero      <= (acc_d == '0);
                    valid     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - scoreboard bench for nibble_serial_adder (NIBBLES = 4)
module tb_nibble_serial_adder;
    import alu_pkg::*;

    localparam int NIB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        carry_in = 1'b0;
    logic        busy, done, valid, err, carry_out, overflow, zero;
    logic [15:0] sum;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int busy_cnt = 0;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        v;
        logic        z;
        int          acc;
    } exp_t;

    exp_t exp_q[$];

    nibble_serial_adder #(.NIBBLES(NIB)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .valid     (valid),
        .err       (err),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // monitor: pops the scoreboard whenever the DUT signals completion
    always @(negedge clk) begin
        if (reset) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no result pending");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sum", sum, e.s);
                    chk("carry_out", carry_out, e.c);
                    chk("overflow", overflow, e.v);
                    chk("zero", zero, e.z);
                    chk("valid_at_done", valid, 1);
                    chk("done_latency", cyc - e.acc, NIB);
                    chk("busy_cycles", busy_cnt, NIB);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic push_exp(input logic [15:0] s, input logic c, input logic v, input logic z);
        exp_t e;
        e.s = s; e.c = c; e.v = v; e.z = z;
        e.acc = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [1:0] o, input logic [15:0] aa, input logic [15:0] bb, input logic ci);
        @(negedge clk);
        start = 1'b1; op = o; a = aa; b = bb; carry_in = ci;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            if (done) break;
            @(negedge clk);
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got done=0 expected done within 20 cycles");
        end
    endtask

    task automatic do_op(input logic [1:0] o, input logic [15:0] aa, input logic [15:0] bb, input logic ci,
                         input logic [15:0] es, input logic ec, input logic ev, input logic ez);
        issue(o, aa, bb, ci);
        push_exp(es, ec, ev, ez);
        @(negedge clk);
        start = 1'b0;
        chk("valid_drop", valid, 0);
        chk("busy_after_accept", busy, 1);
        wait_done();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_sum"}, sum, 0);
        chk({tag, "_carry_out"}, carry_out, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_zero"}, zero, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;

        do_op(ALU_OP_ADD, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        do_op(ALU_OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        do_op(ALU_OP_ADD, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        do_op(ALU_OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        do_op(ALU_OP_SUB, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        do_op(ALU_OP_SUB, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        do_op(ALU_OP_SUB, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);

        // illegal opcode in IDLE: err pulse only, last result stays valid
        issue(2'b11, 16'hAAAA, 16'h5555, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("illegal_err", err, 1);
        chk("illegal_busy", busy, 0);
        chk("illegal_valid", valid, 1);
        chk("illegal_sum_kept", sum, 16'h0000);
        @(negedge clk);
        chk("illegal_err_pulse", err, 0);

        // start (even illegal) during RUN is ignored
        issue(ALU_OP_ADD, 16'h1111, 16'h2222, 1'b0);
        push_exp(16'h3333, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 2'b11; a = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        chk("run_start_no_err", err, 0);
        chk("run_start_busy", busy, 1);
        wait_done();
        @(negedge clk);

        // reset in the second RUN cycle aborts the operation
        issue(ALU_OP_ADD, 16'h0F0F, 16'h0101, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_all_zero("abort");
        @(negedge clk);
        reset = 1'b0;

        // back-to-back: start held through DONE
        issue(ALU_OP_ADD, 16'h1000, 16'h0234, 1'b0);
        push_exp(16'h1234, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("b2b_valid_drop", valid, 0);
        wait_done();
        op = ALU_OP_SUB; a = 16'h5000; b = 16'h1000;
        push_exp(16'h4000, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_accept_busy", busy, 1);
        chk("b2b_valid_drop2", valid, 0);
        wait_done();
        @(negedge clk);

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
